seq_mult16x19_ctrl: RTL
=======================

Name: seq_mult16x19_ctrl

Overview:
Sequential shift-add multiplier controller. Computes a 16-bit x 19-bit unsigned product (35 bits), one multiplier bit per cycle, MSB first.
Drives the 35-bit + 16-bit zero-extended adder stage (customAdder35_19) directly upstream through its A/B operand ports. Consumes that adder's 36-bit Sum and feeds it back into the accumulator.
Sits in the multiply datapath between operand fetch and the multiply result writeback.

Parameters:
MCAND_W, 16, multiplicand width; must equal the adder B width.
MPLR_W, 19, multiplier width; iteration count.
PROD_W, 35, product/accumulator width; must equal MCAND_W+MPLR_W and the adder A width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE
mcand  in  16  multiplicand, captured when start is accepted
mplr  in  19  multiplier, captured when start is accepted
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; product is valid
product  out  35  result; held until the next accepted start
add_a  out  35  to adder A
add_b  out  16  to adder B
add_sum  in  36  from adder Sum

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: when rst_n is low at a clk edge:
  - state=IDLE.
  - acc, mcand_r, mplr_r, cnt are cleared to 0.
  - product=0, done=0, busy=0.
  - Reset in mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - add_a=0, add_b=0.
  - On start=1 at edge E0: latch mcand_r/mplr_r, acc=0, cnt=MPLR_W-1 (18), go to RUN.
- RUN, one iteration per edge, for E1 through E19:
  - add_a = {acc[33:0],1'b0}, i.e. acc shifted left by 1.
  - add_b = mplr_r[cnt] ? mcand_r : 0.
  - acc <= add_sum[34:0].
  - cnt decrements by 1.
  - At the edge where cnt==0: product <= add_sum[34:0], go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1 in that cycle, add_a/add_b=0.
  - Next edge goes to IDLE.
  - done is first visible in the cycle after E19, i.e. 19 edges after start is accepted.
- Throughput: one multiply per 21 cycles. A new start is accepted in the IDLE cycle following DONE.
- start while busy=1 is ignored. Operand changes while busy have no effect.
- Width rule:
  - add_sum[35] is always 0 by construction, since the final product is below 2^35.
  - The intermediate acc never exceeds 2^35-1.
  - add_sum[35] is discarded and not flagged.
- add_a/add_b are combinational from registered state only; there is no combinational path from start to the adder.

Optional Feature:
EARLY_TERM_EN
- Defined: if start is accepted with mcand==0 or mplr==0, then at E0 the block sets product=0 and goes directly to DONE. done is visible the cycle after E0 and RUN is skipped.
- Undefined: zero operands take the full 19-iteration path and yield product=0 with normal timing.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 2 cycles, then high.
  - Required: product=0, done=0, busy=0, add_a=0, add_b=0.
- Basic multiply:
  - Stimulus: mcand=3, mplr=5, start one cycle.
  - Required: busy high from the cycle after E0; done pulse one cycle, 19 edges after accept; product=35'd15; busy low the cycle after.
- Maximum operands:
  - Stimulus: mcand=16'hFFFF, mplr=19'h7FFFF.
  - Required: product=35'h7FFF70001; add_sum[35] observed 0 on every iteration.
- Start while busy:
  - Stimulus: mcand=2, mplr=7, then a second start with mcand=9, mplr=9 at iteration 5.
  - Required: product=14, only one done pulse; afterwards a fresh start with 9x9 gives product=81.
- Reset mid-operation:
  - Stimulus: rst_n low for one cycle at iteration 10 of 100x1000.
  - Required: no done pulse, product=0, state IDLE; a subsequent 100x1000 gives product=100000.
- Zero operand:
  - Stimulus: mcand=0, mplr=19'h12345.
  - Required, with EARLY_TERM_EN: done in the cycle after E0.
  - Required, without EARLY_TERM_EN: done 19 edges after accept.
  - Required in both builds: product=0.

Source files
------------

// File: rtl/seq_mult16x19_ctrl.sv
// seq_mult16x19_ctrl: sequential shift-add multiplier controller.
// Computes an unsigned MCAND_W x MPLR_W product. It consumes one multiplier bit
// per cycle, starting from the MSB. The adder sits outside this block: the block
// drives the adder through add_a/add_b and takes add_sum back into the accumulator.
// Optional build macro EARLY_TERM_EN: a start with a zero operand skips the RUN
// phase and completes immediately with product 0.
module seq_mult16x19_ctrl #(
    parameter int MCAND_W = 16,
    parameter int MPLR_W  = 19,
    parameter int PROD_W  = 35
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MCAND_W-1:0] mcand,
    input  logic [MPLR_W-1:0]  mplr,
    output logic               busy,
    output logic               done,
    output logic [PROD_W-1:0]  product,
    output logic [PROD_W-1:0]  add_a,
    output logic [MCAND_W-1:0] add_b,
    input  logic [PROD_W:0]    add_sum
);

    localparam int CNT_W = $clog2(MPLR_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MPLR_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [MCAND_W-1:0] mcand_q, mcand_d;
    logic [MPLR_W-1:0]  mplr_q, mplr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PROD_W-1:0]  product_q, product_d;

    // The final product fits in PROD_W bits, so the adder carry-out is always 0.
    logic sum_msb_unused;
    assign sum_msb_unused = add_sum[PROD_W];

    // Next-state, datapath update and adder operand selection.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        add_a     = '0;
        add_b     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = mcand;
                    mplr_d  = mplr;
                    acc_d   = '0;
                    cnt_d   = CNT_LAST;
                    state_d = S_RUN;
`ifdef EARLY_TERM_EN
                    if ((mcand == '0) || (mplr == '0)) begin
                        product_d = '0;
                        state_d   = S_DONE;
                    end
`else
`endif
                end
            end
            S_RUN: begin
                // MSB-first: double the running sum, then add the multiplicand if the current bit is set.
                add_a = {acc_q[PROD_W-2:0], 1'b0};
                add_b = mplr_q[cnt_q] ? mcand_q : '0;
                acc_d = add_sum[PROD_W-1:0];
                if (cnt_q == '0) begin
                    product_d = add_sum[PROD_W-1:0];
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule
